// File: rtl/key_entry_buffer.sv
// Keypad entry buffer: collects digit strobes into a shift buffer with
// clear, backspace and a commit hand-off of a complete entry.
module key_entry_buffer #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4,
  parameter int MAX_KEY    = 9,
  localparam int CW        = $clog2(NUM_DIGITS + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DIGIT_W-1:0]            key,
  input  logic                          key_valid,
  input  logic                          key_clear,
  input  logic                          key_back,
  input  logic                          commit,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  output logic [CW-1:0]                 digit_count,
  output logic                          full,
  output logic [NUM_DIGITS*DIGIT_W-1:0] committed,
  output logic                          commit_valid,
  output logic                          err
);

  localparam int NW = NUM_DIGITS * DIGIT_W;
  localparam logic [CW-1:0] CNT_MAX = CW'(NUM_DIGITS);
  localparam logic [DIGIT_W-1:0] KEY_MAX = DIGIT_W'(MAX_KEY);

  logic [NW-1:0]  digits_q, digits_d;
  logic [CW-1:0]  count_q, count_d;
  logic [NW-1:0]  commit_q, commit_d;
  logic           cv_q, cv_d;
  logic           err_q, err_d;
  logic           full_w;

  assign full_w = (count_q == CNT_MAX);

  // Priority: clear > commit > back > key; lower ones are dropped silently
  always_comb begin
    digits_d = digits_q;
    count_d  = count_q;
    commit_d = commit_q;
    cv_d     = 1'b0;
    err_d    = 1'b0;
    priority case (1'b1)
      key_clear: begin
        digits_d = '0;
        count_d  = '0;
      end
      commit: begin
        if (full_w) begin
          commit_d = digits_q;
          cv_d     = 1'b1;
          digits_d = '0;
          count_d  = '0;
        end else begin
          err_d = 1'b1;
        end
      end
      key_back: begin
        if (count_q != '0) begin
          digits_d = digits_q >> DIGIT_W;
          count_d  = count_q - 1'b1;
        end
      end
      key_valid: begin
        if (key <= KEY_MAX) begin
          digits_d = {digits_q[NW-DIGIT_W-1:0], key};
          if (!full_w) count_d = count_q + 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digits_q <= '0;
      count_q  <= '0;
      commit_q <= '0;
      cv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      digits_q <= digits_d;
      count_q  <= count_d;
      commit_q <= commit_d;
      cv_q     <= cv_d;
      err_q    <= err_d;
    end
  end

  assign digits       = digits_q;
  assign digit_count  = count_q;
  assign full         = full_w;
  assign committed    = commit_q;
  assign commit_valid = cv_q;
  assign err          = err_q;

endmodule

// File: tb/tb_key_entry_buffer.sv
// Scoreboard bench: directed steps push expected outputs, a monitor
// pops and compares one cycle later; commit pulses are checked separately.
module tb_key_entry_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] k4, k6;
  logic       kv4, clr4, bk4, cm4;
  logic       kv6, clr6, bk6, cm6;

  logic [15:0] dg4, cmt4;
  logic [2:0]  cnt4;
  logic        full4, cv4, err4;
  logic [23:0] dg6, cmt6;
  logic [2:0]  cnt6;
  logic        full6, cv6, err6;

  key_entry_buffer u4 (
    .clk(clk), .reset(rst), .key(k4), .key_valid(kv4),
    .key_clear(clr4), .key_back(bk4), .commit(cm4),
    .digits(dg4), .digit_count(cnt4), .full(full4),
    .committed(cmt4), .commit_valid(cv4), .err(err4)
  );

  key_entry_buffer #(.NUM_DIGITS(6), .DIGIT_W(4)) u6 (
    .clk(clk), .reset(rst), .key(k6), .key_valid(kv6),
    .key_clear(clr6), .key_back(bk6), .commit(cm6),
    .digits(dg6), .digit_count(cnt6), .full(full6),
    .committed(cmt6), .commit_valid(cv6), .err(err6)
  );

  typedef struct {
    bit          sel;
    logic [23:0] dg;
    int          cnt;
    bit          full;
    logic [23:0] cm;
    bit          cv;
    bit          err;
  } exp_t;

  typedef struct {
    bit          sel;
    logic [23:0] val;
  } cexp_t;

  exp_t  q[$];
  cexp_t cq[$];
  int    tests = 0;
  int    fails = 0;

  task automatic step(input bit sel, input bit r, input bit clr,
                      input bit cm, input bit bk, input bit kv,
                      input logic [3:0] k, input logic [23:0] edg,
                      input int ecnt, input logic [23:0] ecm,
                      input bit ecv, input bit eerr);
    exp_t e;
    cexp_t c;
    @(negedge clk);
    rst = r;
    k4 = sel ? 4'h0 : k;  kv4 = !sel && kv;
    clr4 = !sel && clr;   bk4 = !sel && bk;  cm4 = !sel && cm;
    k6 = sel ? k : 4'h0;  kv6 = sel && kv;
    clr6 = sel && clr;    bk6 = sel && bk;   cm6 = sel && cm;
    e.sel = sel; e.dg = edg; e.cnt = ecnt;
    e.full = (ecnt == (sel ? 6 : 4));
    e.cm = ecm; e.cv = ecv; e.err = eerr;
    q.push_back(e);
    if (ecv) begin
      c.sel = sel; c.val = ecm;
      cq.push_back(c);
    end
  endtask

  // per-cycle state monitor
  initial begin
    exp_t e;
    logic [23:0] adg, acm;
    int acnt;
    bit afull, acv, aerr;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        adg   = e.sel ? dg6 : {8'h0, dg4};
        acm   = e.sel ? cmt6 : {8'h0, cmt4};
        acnt  = e.sel ? int'(cnt6) : int'(cnt4);
        afull = e.sel ? full6 : full4;
        acv   = e.sel ? cv6 : cv4;
        aerr  = e.sel ? err6 : err4;
        tests++;
        if (adg !== e.dg || acnt != e.cnt || afull !== e.full ||
            acm !== e.cm || acv !== e.cv || aerr !== e.err) begin
          fails++;
          $display("FAIL state#%0d dut%0d: got dg=%h cnt=%0d full=%b cm=%h cv=%b err=%b want dg=%h cnt=%0d full=%b cm=%h cv=%b err=%b",
                   tests, e.sel ? 6 : 4, adg, acnt, afull, acm, acv, aerr,
                   e.dg, e.cnt, e.full, e.cm, e.cv, e.err);
        end
      end
    end
  end

  // commit hand-off monitor
  initial begin
    cexp_t c;
    logic [23:0] act;
    forever begin
      @(posedge clk);
      #2;
      if (cv4 === 1'b1 || cv6 === 1'b1) begin
        act = cv6 ? cmt6 : {8'h0, cmt4};
        tests++;
        if (cq.size() == 0) begin
          fails++;
          $display("FAIL commit: unexpected pulse, got %h want none", act);
        end else begin
          c = cq.pop_front();
          if (c.sel != cv6 || act !== c.val) begin
            fails++;
            $display("FAIL commit: got %h on dut%0d want %h on dut%0d",
                     act, cv6 ? 6 : 4, c.val, c.sel ? 6 : 4);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    k4 = '0; kv4 = 0; clr4 = 0; bk4 = 0; cm4 = 0;
    k6 = '0; kv6 = 0; clr6 = 0; bk6 = 0; cm6 = 0;
    //   sel rst clr cm bk kv key  digits     cnt committed  cv err
    step(0, 1, 0, 0, 0, 0, 4'h0, 24'h0,      0, 24'h0,      0, 0);
    step(1, 1, 0, 0, 0, 0, 4'h0, 24'h0,      0, 24'h0,      0, 0);
    // 1,2,3,0 then commit
    step(0, 0, 0, 0, 0, 1, 4'h1, 24'h0001,   1, 24'h0,      0, 0);
    step(0, 0, 0, 0, 0, 1, 4'h2, 24'h0012,   2, 24'h0,      0, 0);
    step(0, 0, 0, 0, 0, 1, 4'h3, 24'h0123,   3, 24'h0,      0, 0);
    step(0, 0, 0, 0, 0, 1, 4'h0, 24'h1230,   4, 24'h0,      0, 0);
    step(0, 0, 0, 1, 0, 0, 4'h0, 24'h0,      0, 24'h1230,   1, 0);
    // rolling entry 1..5
    step(0, 0, 0, 0, 0, 1, 4'h1, 24'h0001,   1, 24'h1230,   0, 0);
    step(0, 0, 0, 0, 0, 1, 4'h2, 24'h0012,   2, 24'h1230,   0, 0);
    step(0, 0, 0, 0, 0, 1, 4'h3, 24'h0123,   3, 24'h1230,   0, 0);
    step(0, 0, 0, 0, 0, 1, 4'h4, 24'h1234,   4, 24'h1230,   0, 0);
    step(0, 0, 0, 0, 0, 1, 4'h5, 24'h2345,   4, 24'h1230,   0, 0);
    step(0, 0, 1, 0, 0, 0, 4'h0, 24'h0,      0, 24'h1230,   0, 0);
    // backspace, saturating at zero
    step(0, 0, 0, 0, 0, 1, 4'h7, 24'h0007,   1, 24'h1230,   0, 0);
    step(0, 0, 0, 0, 0, 1, 4'h8, 24'h0078,   2, 24'h1230,   0, 0);
    step(0, 0, 0, 0, 1, 0, 4'h0, 24'h0007,   1, 24'h1230,   0, 0);
    step(0, 0, 0, 0, 1, 0, 4'h0, 24'h0,      0, 24'h1230,   0, 0);
    step(0, 0, 0, 0, 1, 0, 4'h0, 24'h0,      0, 24'h1230,   0, 0);
    // invalid key and short commit
    step(0, 0, 0, 0, 0, 1, 4'h4, 24'h0004,   1, 24'h1230,   0, 0);
    step(0, 0, 0, 0, 0, 1, 4'h5, 24'h0045,   2, 24'h1230,   0, 0);
    step(0, 0, 0, 0, 0, 1, 4'hA, 24'h0045,   2, 24'h1230,   0, 1);
    step(0, 0, 0, 1, 0, 0, 4'h0, 24'h0045,   2, 24'h1230,   0, 1);
    step(0, 0, 0, 0, 0, 0, 4'h0, 24'h0045,   2, 24'h1230,   0, 0);
    // commit beats back beats key
    step(0, 0, 0, 0, 1, 1, 4'h9, 24'h0004,   1, 24'h1230,   0, 0);
    step(0, 0, 0, 0, 0, 1, 4'h5, 24'h0045,   2, 24'h1230,   0, 0);
    step(0, 0, 0, 1, 1, 1, 4'h9, 24'h0045,   2, 24'h1230,   0, 1);
    // clear beats commit and key while full
    step(0, 0, 0, 0, 0, 1, 4'h6, 24'h0456,   3, 24'h1230,   0, 0);
    step(0, 0, 0, 0, 0, 1, 4'h7, 24'h4567,   4, 24'h1230,   0, 0);
    step(0, 0, 1, 1, 0, 1, 4'h9, 24'h0,      0, 24'h1230,   0, 0);
    // reset beats commit
    step(0, 0, 0, 0, 0, 1, 4'h2, 24'h0002,   1, 24'h1230,   0, 0);
    step(0, 0, 0, 0, 0, 1, 4'h1, 24'h0021,   2, 24'h1230,   0, 0);
    step(0, 0, 0, 0, 0, 1, 4'h4, 24'h0214,   3, 24'h1230,   0, 0);
    step(0, 0, 0, 0, 0, 1, 4'h5, 24'h2145,   4, 24'h1230,   0, 0);
    step(0, 1, 0, 1, 0, 0, 4'h0, 24'h0,      0, 24'h0,      0, 0);
    // six-digit instance
    step(1, 0, 0, 0, 0, 1, 4'h1, 24'h000001, 1, 24'h0,      0, 0);
    step(1, 0, 0, 0, 0, 1, 4'h2, 24'h000012, 2, 24'h0,      0, 0);
    step(1, 0, 0, 0, 0, 1, 4'h3, 24'h000123, 3, 24'h0,      0, 0);
    step(1, 0, 0, 0, 0, 1, 4'h4, 24'h001234, 4, 24'h0,      0, 0);
    step(1, 0, 0, 0, 0, 1, 4'h5, 24'h012345, 5, 24'h0,      0, 0);
    step(1, 0, 0, 0, 0, 1, 4'h6, 24'h123456, 6, 24'h0,      0, 0);
    step(1, 0, 0, 1, 0, 0, 4'h0, 24'h0,      0, 24'h123456, 1, 0);
    step(1, 0, 0, 0, 0, 0, 4'h0, 24'h0,      0, 24'h123456, 0, 0);
    @(negedge clk);
    kv6 = 0; cm6 = 0;
    repeat (3) @(posedge clk);
    #3;
    tests++;
    if (q.size() != 0 || cq.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d state / %0d commit pending want 0",
               q.size(), cq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
